sync_ram_lsu_adapter: RTL and testbench

//  Load/store front end for the single-port-per-direction sync RAM (1-cycle registered read, byte-strobed write).

---
 rtl/sync_ram_lsu_adapter.sv | 176 +++++++++++++++++
 tb/tb_sync_ram_lsu_adapter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_ram_lsu_adapter.sv
// -----------------------------------------------------------------------------
// sync_ram_lsu_adapter
//
// Load/store front end for a sync RAM with one read port (1-cycle registered
// read) and one byte-strobed write port. Accepts one byte-addressed, sized
// request at a time over valid/ready and returns exactly one response per
// request. Loads are lane-aligned and zero/sign-extended. Misaligned,
// out-of-range and size-3 requests are answered with an error and never
// touch the RAM.
//
// Ports
//   clock, reset                 rising-edge clock, async active-low reset
//   req_valid/req_ready          request handshake (fire = valid & ready)
//   req_addr/wen/size/signed     byte address, store flag, size, load sign flag
//   req_wdata                    right-justified store data
//   resp_valid/resp_ready        response handshake
//   resp_rdata/resp_err          extended load data (0 on store/error), error
//   ram_raddr/ram_waddr          RAM word addresses (straight from req_addr)
//   ram_wstrb/ram_wdata          byte strobes (fire cycle only), replicated data
//   ram_rdata                    RAM read data, valid the cycle after raddr
// -----------------------------------------------------------------------------
module sync_ram_lsu_adapter #(
    parameter int RAM_ADDR_BITS = 13,
    parameter int ADDR_WIDTH    = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_WIDTH-1:0]    req_addr,
    input  logic                     req_wen,
    input  logic [1:0]               req_size,
    input  logic                     req_signed,
    input  logic [31:0]              req_wdata,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [31:0]              resp_rdata,
    output logic                     resp_err,
    output logic [RAM_ADDR_BITS-1:0] ram_raddr,
    output logic [RAM_ADDR_BITS-1:0] ram_waddr,
    output logic [3:0]               ram_wstrb,
    output logic [31:0]              ram_wdata,
    input  logic [31:0]              ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD_WAIT,
        S_RESP
    } state_t;

    state_t      state_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;

    // Request fields kept for the read-data alignment step; datapath only,
    // so they carry no reset.
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        signed_q;

    logic        fire;
    logic [1:0]  off;
    logic        hi_nz;
    logic        req_err;
    logic [3:0]  strb_sel;

    // Shift the addressed lane down, truncate to the access size, extend.
    function automatic logic [31:0] align_load(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [1:0]  size,
                                               input logic        sgn);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (size)
            2'd0:    align_load = sgn ? {{24{sh[7]}}, sh[7:0]}   : {24'b0, sh[7:0]};
            2'd1:    align_load = sgn ? {{16{sh[15]}}, sh[15:0]} : {16'b0, sh[15:0]};
            default: align_load = sh;
        endcase
    endfunction

    assign fire  = req_valid & req_ready_q;
    assign off   = req_addr[1:0];
    // Any address bit above the RAM byte space makes the request out of range.
    assign hi_nz = |req_addr[ADDR_WIDTH-1:RAM_ADDR_BITS+2];

    assign req_err = (req_size == 2'd3)
                   | ((req_size == 2'd1) & off[0])
                   | ((req_size == 2'd2) & (off != 2'd0))
                   | hi_nz;

    always_comb begin
        strb_sel = 4'hF;
        case (req_size)
            2'd0:    strb_sel = 4'b0001 << off;
            2'd1:    strb_sel = 4'b0011 << off;
            default: strb_sel = 4'hF;
        endcase
    end

    always_comb begin
        ram_wdata = req_wdata;
        case (req_size)
            2'd0:    ram_wdata = {4{req_wdata[7:0]}};
            2'd1:    ram_wdata = {2{req_wdata[15:0]}};
            default: ram_wdata = req_wdata;
        endcase
    end

    // The write goes straight out in the accepting cycle; fire is already
    // low during reset because req_ready_q is held at zero.
    assign ram_wstrb = (fire && req_wen && !req_err) ? strb_sel : 4'h0;
    assign ram_raddr = req_addr[RAM_ADDR_BITS+1:2];
    assign ram_waddr = req_addr[RAM_ADDR_BITS+1:2];

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

    always_ff @(posedge clock) begin
        if (fire) begin
            off_q    <= off;
            size_q   <= req_size;
            signed_q <= req_signed;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Also raises ready on the first clock after reset release.
                    req_ready_q <= 1'b1;
                    if (fire) begin
                        req_ready_q <= 1'b0;
                        if (req_err || req_wen) begin
                            resp_err_q   <= req_err;
                            resp_rdata_q <= 32'h0;
                            resp_valid_q <= 1'b1;
                            state_q      <= S_RESP;
                        end else begin
                            state_q <= S_RD_WAIT;
                        end
                    end
                end
                S_RD_WAIT: begin
                    resp_rdata_q <= align_load(ram_rdata, off_q, size_q, signed_q);
                    resp_err_q   <= 1'b0;
                    resp_valid_q <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sync_ram_lsu_adapter.sv
// -----------------------------------------------------------------------------
// tb_sync_ram_lsu_adapter
//
// Directed bench for sync_ram_lsu_adapter with a behavioural sync RAM
// (registered read, byte-strobed write). A table of request records with
// hand-computed results is applied in a loop, followed by hand-written
// sequences for response back-pressure and reset during a pending read.
// -----------------------------------------------------------------------------
module tb_sync_ram_lsu_adapter;

    localparam int RAB = 13;
    localparam int AW  = 32;

    logic           clock;
    logic           reset;
    logic           req_valid;
    logic           req_ready;
    logic [AW-1:0]  req_addr;
    logic           req_wen;
    logic [1:0]     req_size;
    logic           req_signed;
    logic [31:0]    req_wdata;
    logic           resp_valid;
    logic           resp_ready;
    logic [31:0]    resp_rdata;
    logic           resp_err;
    logic [RAB-1:0] ram_raddr;
    logic [RAB-1:0] ram_waddr;
    logic [3:0]     ram_wstrb;
    logic [31:0]    ram_wdata;
    logic [31:0]    ram_rdata;

    sync_ram_lsu_adapter #(.RAM_ADDR_BITS(RAB), .ADDR_WIDTH(AW)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wen    (req_wen),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .ram_raddr  (ram_raddr),
        .ram_waddr  (ram_waddr),
        .ram_wstrb  (ram_wstrb),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural RAM
    logic [31:0] mem [0:(1<<RAB)-1];
    always @(posedge clock) begin
        ram_rdata <= mem[ram_raddr];
        for (int b = 0; b < 4; b++)
            if (ram_wstrb[b]) mem[ram_waddr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end

    // Number of clock edges on which any write strobe was active.
    int wcount;
    always @(posedge clock) if (ram_wstrb != 4'h0) wcount <= wcount + 1;

    int n_checks;
    int n_fail;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic           wen;
        logic [1:0]     size;
        logic           sgn;
        logic [31:0]    addr;
        logic [31:0]    wdata;
        logic           exp_err;
        logic [31:0]    exp_rdata;
        logic [3:0]     exp_wstrb;
        logic [31:0]    exp_wdata;
        logic [RAB-1:0] exp_waddr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic wen, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic exp_err, input logic [31:0] exp_rdata,
                                input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata,
                                input logic [RAB-1:0] exp_waddr);
        vec_t v;
        v.wen = wen; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.exp_err = exp_err; v.exp_rdata = exp_rdata; v.exp_wstrb = exp_wstrb;
        v.exp_wdata = exp_wdata; v.exp_waddr = exp_waddr;
        return v;
    endfunction

    // One complete request/response transaction with immediate response acceptance.
    task automatic run_vec(input vec_t v, input string nm);
        int lat;
        int wc0;
        int exp_lat;
        int exp_w;
        lat = 0;
        while (!req_ready && lat < 10) begin
            @(negedge clock);
            lat++;
        end
        check({nm, " req_ready"}, {31'b0, req_ready}, 32'h1);
        req_valid  = 1'b1;
        req_wen    = v.wen;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        #1;
        check({nm, " wstrb"}, {28'b0, ram_wstrb}, {28'b0, v.exp_wstrb});
        check({nm, " waddr"}, {19'b0, ram_waddr}, {19'b0, v.exp_waddr});
        if (v.wen && !v.exp_err)
            check({nm, " wdata"}, ram_wdata, v.exp_wdata);
        wc0 = wcount;
        @(posedge clock);
        #1;
        // Scramble the request bus: the response must come from captured fields.
        req_valid  = 1'b0;
        req_addr   = 32'hFFFF_FFFF;
        req_size   = 2'd3;
        req_signed = ~v.sgn;
        req_wdata  = 32'h0;
        check({nm, " wstrb_after_fire"}, {28'b0, ram_wstrb}, 32'h0);
        @(negedge clock);
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(negedge clock);
            lat++;
        end
        exp_lat = (v.wen || v.exp_err) ? 1 : 2;
        exp_w   = (v.wen && !v.exp_err) ? 1 : 0;
        check({nm, " latency"}, lat, exp_lat);
        check({nm, " resp_err"}, {31'b0, resp_err}, {31'b0, v.exp_err});
        check({nm, " resp_rdata"}, resp_rdata, v.exp_rdata);
        check({nm, " write_count"}, wcount - wc0, exp_w);
        resp_ready = 1'b1;
        @(posedge clock);
        #1;
        resp_ready = 1'b0;
        check({nm, " resp_valid_after_hs"}, {31'b0, resp_valid}, 32'h0);
        check({nm, " req_ready_after_hs"}, {31'b0, req_ready}, 32'h1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int wc0;
        n_checks   = 0;
        n_fail     = 0;
        wcount     = 0;
        for (int i = 0; i < (1 << RAB); i++) mem[i] = 32'h0;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_wen    = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_wdata  = 32'h0;
        resp_ready = 1'b0;

        // Table: wen size sgn addr wdata | err rdata wstrb wdata waddr
        vecs.push_back(mk(1, 2, 0, 32'h0,    32'hDEADBEEF, 0, 32'h0,        4'hF, 32'hDEADBEEF, 13'h0));
        vecs.push_back(mk(0, 2, 0, 32'h0,    32'h0,        0, 32'hDEADBEEF, 4'h0, 32'h0,        13'h0));
        vecs.push_back(mk(1, 1, 0, 32'h6,    32'hDEADBEEF, 0, 32'h0,        4'hC, 32'hBEEFBEEF, 13'h1));
        vecs.push_back(mk(0, 1, 0, 32'h6,    32'h0,        0, 32'h0000BEEF, 4'h0, 32'h0,        13'h1));
        vecs.push_back(mk(0, 1, 1, 32'h6,    32'h0,        0, 32'hFFFFBEEF, 4'h0, 32'h0,        13'h1));
        vecs.push_back(mk(1, 0, 0, 32'h11,   32'h00000080, 0, 32'h0,        4'h2, 32'h80808080, 13'h4));
        vecs.push_back(mk(0, 0, 1, 32'h11,   32'h0,        0, 32'hFFFFFF80, 4'h0, 32'h0,        13'h4));
        vecs.push_back(mk(0, 0, 0, 32'h11,   32'h0,        0, 32'h00000080, 4'h0, 32'h0,        13'h4));
        vecs.push_back(mk(0, 2, 0, 32'h10,   32'h0,        0, 32'h00008000, 4'h0, 32'h0,        13'h4));
        vecs.push_back(mk(0, 0, 1, 32'h3,    32'h0,        0, 32'hFFFFFFDE, 4'h0, 32'h0,        13'h0));
        vecs.push_back(mk(0, 1, 1, 32'h2,    32'h0,        0, 32'hFFFFDEAD, 4'h0, 32'h0,        13'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,    32'h0,        0, 32'h000000EF, 4'h0, 32'h0,        13'h0));
        vecs.push_back(mk(1, 2, 0, 32'h7FFC, 32'h12345678, 0, 32'h0,        4'hF, 32'h12345678, 13'h1FFF));
        vecs.push_back(mk(0, 2, 0, 32'h7FFC, 32'h0,        0, 32'h12345678, 4'h0, 32'h0,        13'h1FFF));
        vecs.push_back(mk(0, 2, 0, 32'h2,    32'h0,        1, 32'h0,        4'h0, 32'h0,        13'h0));
        vecs.push_back(mk(1, 1, 0, 32'h3,    32'h0000FFFF, 1, 32'h0,        4'h0, 32'h0,        13'h0));
        vecs.push_back(mk(0, 3, 0, 32'h0,    32'h0,        1, 32'h0,        4'h0, 32'h0,        13'h0));
        vecs.push_back(mk(0, 2, 0, 32'h8000, 32'h0,        1, 32'h0,        4'h0, 32'h0,        13'h0));
        vecs.push_back(mk(1, 2, 0, 32'h8000, 32'hFFFFFFFF, 1, 32'h0,        4'h0, 32'h0,        13'h0));
        vecs.push_back(mk(1, 3, 0, 32'h4,    32'hFFFFFFFF, 1, 32'h0,        4'h0, 32'h0,        13'h1));
        vecs.push_back(mk(0, 2, 0, 32'h0,    32'h0,        0, 32'hDEADBEEF, 4'h0, 32'h0,        13'h0));
        vecs.push_back(mk(0, 2, 0, 32'h4,    32'h0,        0, 32'hBEEF0000, 4'h0, 32'h0,        13'h1));

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst resp_valid", {31'b0, resp_valid}, 32'h0);
        check("rst resp_err",   {31'b0, resp_err},   32'h0);
        check("rst resp_rdata", resp_rdata,          32'h0);
        check("rst req_ready",  {31'b0, req_ready},  32'h0);
        check("rst wstrb",      {28'b0, ram_wstrb},  32'h0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < vecs.size(); i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // Back-pressure: response held for three cycles, a competing store waits.
        req_valid  = 1'b1;
        req_wen    = 1'b0;
        req_size   = 2'd2;
        req_signed = 1'b0;
        req_addr   = 32'h7FFC;
        @(posedge clock);
        #1;
        req_wen   = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'hCAFEF00D;
        wc0 = wcount;
        @(negedge clock);
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(negedge clock);
            lat++;
        end
        check("hold latency", lat, 2);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("hold%0d resp_valid", c), {31'b0, resp_valid}, 32'h1);
            check($sformatf("hold%0d resp_rdata", c), resp_rdata, 32'h12345678);
            check($sformatf("hold%0d req_ready", c),  {31'b0, req_ready}, 32'h0);
            check($sformatf("hold%0d wstrb", c),      {28'b0, ram_wstrb}, 32'h0);
            @(negedge clock);
        end
        check("hold write_count", wcount - wc0, 0);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clock);
        #1;
        resp_ready = 1'b0;
        check("hold resp_valid_after_hs", {31'b0, resp_valid}, 32'h0);
        run_vec(mk(1, 2, 0, 32'h20, 32'hCAFEF00D, 0, 32'h0, 4'hF, 32'hCAFEF00D, 13'h8), "hold_st");
        run_vec(mk(0, 2, 0, 32'h20, 32'h0, 0, 32'hCAFEF00D, 4'h0, 32'h0, 13'h8), "hold_ld");

        // Reset while a load is waiting on RAM data.
        req_valid  = 1'b1;
        req_wen    = 1'b0;
        req_size   = 2'd2;
        req_addr   = 32'h0;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        reset     = 1'b0;
        #1;
        check("mid_rst resp_valid", {31'b0, resp_valid}, 32'h0);
        check("mid_rst req_ready",  {31'b0, req_ready},  32'h0);
        check("mid_rst resp_rdata", resp_rdata,          32'h0);
        wc0 = wcount;
        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_addr  = 32'h40;
        req_wdata = 32'h55AA55AA;
        repeat (2) begin
            @(negedge clock);
            check("mid_rst wstrb", {28'b0, ram_wstrb}, 32'h0);
        end
        req_valid = 1'b0;
        reset     = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            check($sformatf("post_rst%0d resp_valid", c), {31'b0, resp_valid}, 32'h0);
        end
        check("post_rst req_ready", {31'b0, req_ready}, 32'h1);
        check("post_rst write_count", wcount - wc0, 0);
        run_vec(mk(0, 2, 0, 32'h40, 32'h0, 0, 32'h0, 4'h0, 32'h0, 13'h10), "post_rst_ld40");
        run_vec(mk(0, 2, 0, 32'h0, 32'h0, 0, 32'hDEADBEEF, 4'h0, 32'h0, 13'h0), "post_rst_ld0");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
